// File: rtl/undo_stack_ctrl.sv
// undo_stack_ctrl: arbitrated 16-entry undo buffer with commit > pop > push priority and an independent peek port
module undo_stack_ctrl #(
  parameter int WIDTH = 16,
  parameter int AW = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_req,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_ack,
  input  logic             pop_req,
  output logic             pop_ack,
  output logic [WIDTH-1:0] pop_data,
  output logic             pop_valid,
  input  logic             peek_req,
  input  logic [AW-1:0]    peek_off,
  output logic [WIDTH-1:0] peek_data,
  output logic             peek_valid,
  output logic             peek_miss,
  input  logic             commit,
  output logic [AW-1:0]    sp,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);
  localparam int DEPTH = 2 ** AW;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_sp;
  logic [AW:0] r_count;
  logic w_pop_grant, w_push_grant;
  logic [AW-1:0] w_top, w_peek_addr;
  assign w_top = r_sp - AW'(1);
  assign w_peek_addr = w_top - peek_off;
  assign full = r_count == (AW+1)'(DEPTH);
  assign empty = r_count == '0;
  assign w_pop_grant = ~reset & ~commit & pop_req & ~empty;
  assign w_push_grant = ~reset & ~commit & ~pop_req & push_req;
  assign pop_ack = w_pop_grant;
  assign push_ack = w_push_grant;
  assign sp = r_sp;
  assign count = r_count;
  // storage is deliberately left out of reset
  always_ff @(posedge clk)
    if (w_push_grant) r_mem[r_sp] <= push_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sp       <= '0;
      r_count    <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      pop_valid  <= 1'b0;
      pop_data   <= '0;
      peek_valid <= 1'b0;
      peek_miss  <= 1'b0;
      peek_data  <= '0;
    end else begin
      pop_valid  <= w_pop_grant;
      if (w_pop_grant) pop_data <= r_mem[w_top];
      peek_valid <= peek_req;
      peek_miss  <= peek_req & ({1'b0, peek_off} >= r_count);
      if (peek_req) peek_data <= r_mem[w_peek_addr];
      if (commit) begin
        r_sp      <= '0;
        r_count   <= '0;
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else if (pop_req) begin
        if (w_pop_grant) begin
          r_sp    <= w_top;
          r_count <= r_count - (AW+1)'(1);
        end else underflow <= 1'b1;
      end else if (push_req) begin
        r_sp <= r_sp + AW'(1);
        if (full) overflow <= 1'b1;
        else r_count <= r_count + (AW+1)'(1);
      end
    end
  end
endmodule

// File: tb/tb_undo_stack_ctrl.sv
// tb_undo_stack_ctrl: randomized scoreboard bench against a queue-based model of the undo stack
module tb_undo_stack_ctrl;
  logic clk = 0, reset = 1, push_req = 0, pop_req = 0, peek_req = 0, commit = 0;
  logic [15:0] push_data = 0;
  logic [3:0] peek_off = 0;
  logic push_ack, pop_ack, pop_valid, peek_valid, peek_miss, full, empty, overflow, underflow;
  logic [15:0] pop_data, peek_data;
  logic [3:0] sp;
  logic [4:0] count;

  undo_stack_ctrl #(.WIDTH(16), .AW(4)) dut (
    .clk(clk), .reset(reset), .push_req(push_req), .push_data(push_data), .push_ack(push_ack),
    .pop_req(pop_req), .pop_ack(pop_ack), .pop_data(pop_data), .pop_valid(pop_valid),
    .peek_req(peek_req), .peek_off(peek_off), .peek_data(peek_data), .peek_valid(peek_valid),
    .peek_miss(peek_miss), .commit(commit), .sp(sp), .count(count), .full(full), .empty(empty),
    .overflow(overflow), .underflow(underflow));

  always #5 clk = ~clk;

  typedef struct { int due; logic [15:0] data; bit miss; } exp_t;
  exp_t pop_q[$], peek_q[$];
  int n_chk = 0, n_fail = 0, cyc = 0;
  int stk[$];
  int msp = 0;
  bit movf = 0, mudf = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", n, cyc, a, e);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (pop_valid === 1'b1) begin
      if (pop_q.size() > 0 && pop_q[0].due == cyc) begin
        e = pop_q.pop_front();
        chk("pop_data", pop_data, e.data);
      end else chk("pop_valid_unexpected", pop_valid, 0);
    end else if (pop_q.size() > 0 && pop_q[0].due == cyc) begin
      void'(pop_q.pop_front());
      chk("pop_valid_missing", pop_valid, 1);
    end
    if (peek_valid === 1'b1) begin
      if (peek_q.size() > 0 && peek_q[0].due == cyc) begin
        e = peek_q.pop_front();
        chk("peek_miss", peek_miss, e.miss);
        if (!e.miss) chk("peek_data", peek_data, e.data);
      end else chk("peek_valid_unexpected", peek_valid, 0);
    end else if (peek_q.size() > 0 && peek_q[0].due == cyc) begin
      void'(peek_q.pop_front());
      chk("peek_valid_missing", peek_valid, 1);
    end
  end

  task automatic step(input bit rst, input bit cm, input bit pu, input logic [15:0] d,
                      input bit po, input bit pk, input logic [3:0] off);
    exp_t e;
    int n;
    @(posedge clk);
    #1;
    reset = rst; commit = cm; push_req = pu; push_data = d; pop_req = po; peek_req = pk; peek_off = off;
    #2;
    n = stk.size();
    chk("count", count, n);
    chk("sp", sp, msp);
    chk("full", full, n == 16);
    chk("empty", empty, n == 0);
    chk("overflow", overflow, movf);
    chk("underflow", underflow, mudf);
    chk("pop_ack", pop_ack, !rst && !cm && po && n > 0);
    chk("push_ack", push_ack, !rst && !cm && !po && pu);
    if (pk && !rst) begin
      e.due = cyc + 1;
      e.miss = off >= n;
      e.data = e.miss ? 16'h0 : 16'(stk[n - 1 - off]);
      peek_q.push_back(e);
    end
    if (rst || cm) begin
      stk.delete(); msp = 0; movf = 0; mudf = 0;
    end else if (po) begin
      if (n > 0) begin
        e.due = cyc + 1; e.miss = 0; e.data = 16'(stk.pop_back());
        pop_q.push_back(e);
        msp = (msp + 15) % 16;
      end else mudf = 1;
    end else if (pu) begin
      if (n == 16) begin void'(stk.pop_front()); movf = 1; end
      stk.push_back(int'(d));
      msp = (msp + 1) % 16;
    end
  endtask

  task automatic push(input logic [15:0] d); step(0, 0, 1, d, 0, 0, 0); endtask
  task automatic pop(); step(0, 0, 0, 0, 1, 0, 0); endtask
  task automatic peek(input logic [3:0] off); step(0, 0, 0, 0, 0, 1, off); endtask
  task automatic idle(); step(0, 0, 0, 0, 0, 0, 0); endtask

  initial begin
    repeat (2) @(posedge clk);
    step(1, 0, 0, 0, 0, 0, 0);
    push(16'h1111); push(16'h2222); push(16'h3333);
    peek(0); peek(2); peek(3);
    step(0, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 17; i++) push(16'(i));
    peek(0); peek(15);
    step(1, 0, 0, 0, 0, 0, 0);
    pop(); idle(); pop(); idle();
    step(0, 1, 0, 0, 0, 0, 0);
    push(16'h1234); push(16'hBEEF);
    step(0, 0, 1, 16'h5555, 1, 0, 0);
    push(16'h5555); idle(); idle();
    for (int i = 0; i < 17; i++) push(16'(16'h100 + i));
    for (int i = 0; i < 11; i++) pop();
    step(0, 1, 1, 16'h7777, 0, 1, 4'd2);
    idle();
    for (int i = 0; i < 4; i++) push(16'(16'h40 + i));
    step(1, 0, 1, 16'h9999, 0, 0, 0);
    push(16'hA5A5); peek(0); idle();
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 59) == 0, $urandom_range(0, 24) == 0, $urandom_range(0, 1) == 1,
           16'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, 4'($urandom));
    repeat (3) idle();
    chk("pop_q_drained", pop_q.size(), 0);
    chk("peek_q_drained", peek_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
